// File: rtl/latch_q_filter.sv
// Synchronises an asynchronous latch q output, debounces it into q_stable, and
// reports edge pulses, a saturating transition count and a sticky glitch flag.
module latch_q_filter #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_in,
  input  logic             clr,
  output logic             q_sync,
  output logic             q_stable,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] toggle_count,
  output logic             glitch_seen
);

  localparam int unsigned      DB_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        db_cnt;
  logic [DB_W-1:0]        db_next;
  logic                   glitch_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], q_in};
    end
  end

  assign q_sync  = sync_q[SYNC_STAGES-1];
  assign db_next = db_cnt + DB_W'(1);

  // A pending transition is abandoned when the sampled level returns to the stable one.
  always_comb begin
    glitch_set = 1'b0;
    if ((state == WAIT_HIGH && !q_sync) || (state == WAIT_LOW && q_sync)) begin
      glitch_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE_LOW;
      db_cnt     <= '0;
      q_stable   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (q_sync) begin
            if (STABLE_CYCLES == 1) begin
              state      <= IDLE_HIGH;
              q_stable   <= 1'b1;
              rise_pulse <= 1'b1;
              db_cnt     <= '0;
            end else begin
              state  <= WAIT_HIGH;
              db_cnt <= DB_W'(1);
            end
          end
        end
        WAIT_HIGH: begin
          if (q_sync) begin
            if (db_next == DB_LAST) begin
              state      <= IDLE_HIGH;
              q_stable   <= 1'b1;
              rise_pulse <= 1'b1;
              db_cnt     <= '0;
            end else begin
              db_cnt <= db_next;
            end
          end else begin
            state  <= IDLE_LOW;
            db_cnt <= '0;
          end
        end
        IDLE_HIGH: begin
          if (!q_sync) begin
            if (STABLE_CYCLES == 1) begin
              state      <= IDLE_LOW;
              q_stable   <= 1'b0;
              fall_pulse <= 1'b1;
              db_cnt     <= '0;
            end else begin
              state  <= WAIT_LOW;
              db_cnt <= DB_W'(1);
            end
          end
        end
        WAIT_LOW: begin
          if (!q_sync) begin
            if (db_next == DB_LAST) begin
              state      <= IDLE_LOW;
              q_stable   <= 1'b0;
              fall_pulse <= 1'b1;
              db_cnt     <= '0;
            end else begin
              db_cnt <= db_next;
            end
          end else begin
            state  <= IDLE_HIGH;
            db_cnt <= '0;
          end
        end
        default: begin
          state  <= IDLE_LOW;
          db_cnt <= '0;
        end
      endcase
    end
  end

  // Counting off the registered pulses lets a clr in the pulse cycle win over the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_count <= '0;
      glitch_seen  <= 1'b0;
    end else if (clr) begin
      toggle_count <= '0;
      glitch_seen  <= 1'b0;
    end else begin
      if ((rise_pulse || fall_pulse) && (toggle_count != '1)) begin
        toggle_count <= toggle_count + CNT_W'(1);
      end
      if (glitch_set) begin
        glitch_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_latch_q_filter.sv
// Bench for latch_q_filter: default instance plus a CNT_W=2 instance for saturation,
// with a pulse scoreboard checked every cycle.
module tb_latch_q_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       q_in;
  logic       clr;
  logic       q_sync, q_stable, rise_pulse, fall_pulse, glitch_seen;
  logic [7:0] toggle_count;
  logic       q_sync2, q_stable2, rise2, fall2, glitch_seen2;
  logic [1:0] toggle_count2;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          exp_cnt = 0;
  int          exp_cnt2 = 0;

  typedef struct {
    int unsigned cyc;
    bit          rise;
  } ev_t;
  ev_t sb[$];

  latch_q_filter #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .clr(clr),
    .q_sync(q_sync), .q_stable(q_stable), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .toggle_count(toggle_count), .glitch_seen(glitch_seen)
  );

  latch_q_filter #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .clr(clr),
    .q_sync(q_sync2), .q_stable(q_stable2), .rise_pulse(rise2),
    .fall_pulse(fall2), .toggle_count(toggle_count2), .glitch_seen(glitch_seen2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse scoreboard: each qualified input change is due exactly 6 edges after it is driven.
  always @(negedge clk) begin
    bit er, ef;
    er = 1'b0;
    ef = 1'b0;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      er = sb[0].rise;
      ef = !sb[0].rise;
      void'(sb.pop_front());
    end
    checks++;
    if ({rise_pulse, fall_pulse} !== {er, ef}) begin
      errors++;
      $display("FAIL pulse cyc=%0d got rise=%b fall=%b want rise=%b fall=%b",
               cyc, rise_pulse, fall_pulse, er, ef);
    end
    checks++;
    if ({rise2, fall2} !== {er, ef}) begin
      errors++;
      $display("FAIL pulse2 cyc=%0d got rise=%b fall=%b want rise=%b fall=%b",
               cyc, rise2, fall2, er, ef);
    end
  end

  task automatic expect_edge(input bit rise);
    ev_t e;
    e.cyc  = cyc + 6;
    e.rise = rise;
    sb.push_back(e);
    exp_cnt++;
    if (exp_cnt2 < 3) exp_cnt2++;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({q_sync, q_stable, rise_pulse, fall_pulse, toggle_count, glitch_seen} !== '0) begin
      errors++;
      $display("FAIL reset_init got %b want 0",
               {q_sync, q_stable, rise_pulse, fall_pulse, toggle_count, glitch_seen});
    end
    rst_n = 1'b1;
    @(negedge clk);
    q_in = 1'b1;
    expect_edge(1'b1);
    repeat (8) @(negedge clk);
    checks++;
    if (q_stable !== 1'b1 || toggle_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL first_rise got stable=%b count=%0d want 1 %0d", q_stable, toggle_count, exp_cnt);
    end
    #2 rst_n = 1'b0;
    exp_cnt  = 0;
    exp_cnt2 = 0;
    #1;
    checks++;
    if ({q_sync, q_stable, rise_pulse, fall_pulse, toggle_count, glitch_seen, q_sync2} !== '0) begin
      errors++;
      $display("FAIL async_reset got %b want 0",
               {q_sync, q_stable, rise_pulse, fall_pulse, toggle_count, glitch_seen, q_sync2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    expect_edge(1'b1);
    repeat (5) @(negedge clk);
    checks++;
    if (q_stable !== 1'b0) begin
      errors++;
      $display("FAIL reset_lat5 got %b want 0", q_stable);
    end
    @(negedge clk);
    checks++;
    if (q_stable !== 1'b1) begin
      errors++;
      $display("FAIL reset_lat6 got %b want 1", q_stable);
    end
    @(negedge clk);
  endtask

  task automatic test_clean_rise;
    q_in = 1'b0;
    expect_edge(1'b0);
    repeat (7) @(negedge clk);
    q_in = 1'b1;
    expect_edge(1'b1);
    @(negedge clk);
    checks++;
    if (q_sync !== 1'b0) begin
      errors++;
      $display("FAIL sync_edge1 got %b want 0", q_sync);
    end
    @(negedge clk);
    checks++;
    if (q_sync !== 1'b1) begin
      errors++;
      $display("FAIL sync_edge2 got %b want 1", q_sync);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q_stable !== 1'b0) begin
      errors++;
      $display("FAIL rise_lat5 got %b want 0", q_stable);
    end
    @(negedge clk);
    checks++;
    if (q_stable !== 1'b1 || rise_pulse !== 1'b1) begin
      errors++;
      $display("FAIL rise_lat6 got stable=%b rise=%b want 1 1", q_stable, rise_pulse);
    end
    @(negedge clk);
    checks++;
    if (rise_pulse !== 1'b0 || toggle_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL rise_after got rise=%b count=%0d want 0 %0d", rise_pulse, toggle_count, exp_cnt);
    end
  endtask

  task automatic test_glitch;
    q_in = 1'b0;
    expect_edge(1'b0);
    repeat (7) @(negedge clk);
    checks++;
    if (glitch_seen !== 1'b0) begin
      errors++;
      $display("FAIL glitch_pre got %b want 0", glitch_seen);
    end
    q_in = 1'b1;
    repeat (3) @(negedge clk);
    q_in = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (q_stable !== 1'b0 || glitch_seen !== 1'b1 || glitch_seen2 !== 1'b1 ||
        toggle_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL glitch got stable=%b glitch=%b glitch2=%b count=%0d want 0 1 1 %0d",
               q_stable, glitch_seen, glitch_seen2, toggle_count, exp_cnt);
    end
  endtask

  task automatic test_clr_collision;
    q_in = 1'b1;
    expect_edge(1'b1);
    repeat (7) @(negedge clk);
    q_in = 1'b0;
    expect_edge(1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if (fall_pulse !== 1'b1 || q_stable !== 1'b0) begin
      errors++;
      $display("FAIL clr_fall got fall=%b stable=%b want 1 0", fall_pulse, q_stable);
    end
    clr      = 1'b1;
    exp_cnt  = 0;
    exp_cnt2 = 0;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (toggle_count !== 8'd0 || toggle_count2 !== 2'd0 || glitch_seen !== 1'b0 ||
        fall_pulse !== 1'b0) begin
      errors++;
      $display("FAIL clr_after got count=%0d count2=%0d glitch=%b fall=%b want 0 0 0 0",
               toggle_count, toggle_count2, glitch_seen, fall_pulse);
    end
    q_in = 1'b1;
    repeat (3) @(negedge clk);
    q_in = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (glitch_seen !== 1'b0) begin
      errors++;
      $display("FAIL clr_glitch got %b want 0", glitch_seen);
    end
    @(negedge clk);
    checks++;
    if (glitch_seen !== 1'b0 || q_stable !== 1'b0) begin
      errors++;
      $display("FAIL clr_glitch_hold got glitch=%b stable=%b want 0 0", glitch_seen, q_stable);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 5; i++) begin
      q_in = (i % 2 == 0);
      expect_edge(q_in);
      repeat (7) @(negedge clk);
      checks++;
      if (toggle_count2 !== 2'(exp_cnt2) || toggle_count !== 8'(exp_cnt)) begin
        errors++;
        $display("FAIL sat step=%0d got count2=%0d count=%0d want %0d %0d",
                 i, toggle_count2, toggle_count, exp_cnt2, exp_cnt);
      end
    end
  endtask

  task automatic test_mid_reset;
    q_in = 1'b0;
    expect_edge(1'b0);
    repeat (7) @(negedge clk);
    q_in = 1'b1;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    q_in     = 1'b0;
    exp_cnt  = 0;
    exp_cnt2 = 0;
    #1;
    checks++;
    if (q_stable !== 1'b0 || q_sync !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got stable=%b sync=%b want 0 0", q_stable, q_sync);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (q_stable !== 1'b0 || q_stable2 !== 1'b0 || toggle_count !== 8'd0 || glitch_seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_after got stable=%b stable2=%b count=%0d glitch=%b want 0 0 0 0",
               q_stable, q_stable2, toggle_count, glitch_seen);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    q_in  = 1'b0;
    clr   = 1'b0;
    test_reset;
    test_clean_rise;
    test_glitch;
    test_clr_collision;
    test_saturation;
    test_mid_reset;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
